// File: rtl/sigma_delta_adc_mc_if.sv
// Sample stream from the multichannel sigma-delta ADC: unsigned and signed views of one channel per beat.
// Handshake: a beat transfers on a rising clk edge with m_valid && m_ready; while m_valid && !m_ready the payload is frozen and m_valid stays high.
interface sigma_delta_adc_mc_if #(
    parameter int WDTH = 16,
    parameter int CHW  = 1
);
    logic [WDTH-1:0] m_udata;
    logic [WDTH-1:0] m_sdata;
    logic [CHW-1:0]  m_chan;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;

    modport master (
        output m_udata,
        output m_sdata,
        output m_chan,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_udata,
        input  m_sdata,
        input  m_chan,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/sigma_delta_adc_mc.sv
// Multichannel first-order sigma-delta ADC back end: comparator capture, CIC decimation,
// optional DC removal, and a frame holding bank streamed out one channel per handshake.
module sigma_delta_adc_mc #(
    parameter int NCH      = 2,
    parameter int BOSR     = 256,
    parameter int STGS     = 2,
    parameter int WDTH     = 16,
    parameter int DC_SHIFT = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 dc_en,
    input  logic [NCH-1:0]       adc_lvds_pin,
    output logic [NCH-1:0]       adc_fb_pin,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic                 dbg_seq_state,
    sigma_delta_adc_mc_if.master m_if
);
    localparam int L     = $clog2(BOSR);
    localparam int CIC_W = STGS * L;
    localparam int IW    = CIC_W + 1;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int XW    = WDTH + CIC_W;
    localparam int SHL   = (WDTH >= CIC_W) ? WDTH - CIC_W : 0;
    localparam int SHR   = (WDTH >= CIC_W) ? 0 : CIC_W - WDTH;

    typedef logic [IW-1:0]   cic_t;
    typedef logic [WDTH-1:0] smp_t;
    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} seq_state_e;

    // Conversion path state
    logic [NCH-1:0] adc_in_q, adc_in_d;
    logic [L-1:0]   cnt_q, cnt_d;
    cic_t           integ_q [NCH][STGS];
    cic_t           integ_d [NCH][STGS];
    cic_t           cdly_q  [NCH][STGS];
    cic_t           cdly_d  [NCH][STGS];
    cic_t           comb_q  [NCH];
    cic_t           comb_d  [NCH];
    logic           tick_d1_q, tick_d1_d;
    logic [2:0]     warm_q, warm_d;
    smp_t           u_q   [NCH];
    smp_t           u_d   [NCH];
    smp_t           s_q   [NCH];
    smp_t           s_d   [NCH];
    smp_t           acc_q [NCH];
    smp_t           acc_d [NCH];
    logic           done_q, done_d;

    // Sequencer state
    seq_state_e     state_q, state_d;
    logic [CHW-1:0] chan_q, chan_d;
    smp_t           ub_q [NCH];
    smp_t           ub_d [NCH];
    smp_t           sb_q [NCH];
    smp_t           sb_d [NCH];
    logic           ovr_q, ovr_d;

    // Combinational temporaries
    logic             tick;
    logic             warm_full;
    logic             proc;
    cic_t             run;
    logic [CIC_W-1:0] clamp;
    logic [XW-1:0]    wide;
    smp_t             uval;
    smp_t             xval;
    smp_t             yval;
    logic             fire;
    logic             at_last;
    logic             final_hs;
    logic             ovr_set;

    always_comb begin
        adc_in_d  = en ? adc_lvds_pin : '0;
        cnt_d     = en ? cnt_q + L'(1) : '0;
        tick      = en && (&cnt_q);
        tick_d1_d = en && tick;
        warm_full = (warm_q == 3'(STGS));
        proc      = tick_d1_q && warm_full;
        done_d    = en && proc;

        warm_d = warm_q;
        if (!en) begin
            warm_d = '0;
        end else if (tick_d1_q && !warm_full) begin
            warm_d = warm_q + 3'd1;
        end

        run   = '0;
        clamp = '0;
        wide  = '0;
        uval  = '0;
        xval  = '0;
        yval  = '0;
        for (int c = 0; c < NCH; c++) begin
            // Integrator cascade: each stage adds the previous stage's registered value.
            run = cic_t'(adc_in_q[c]);
            for (int s = 0; s < STGS; s++) begin
                integ_d[c][s] = en ? integ_q[c][s] + run : '0;
                run           = integ_q[c][s];
            end

            run = integ_q[c][STGS-1];
            for (int s = 0; s < STGS; s++) begin
                cdly_d[c][s] = !en ? '0 : (tick ? run : cdly_q[c][s]);
                run          = run - cdly_q[c][s];
            end
            comb_d[c] = !en ? '0 : (tick ? run : comb_q[c]);

            // Full-scale input yields exactly 2^CIC_W, one count past the output range.
            clamp = comb_q[c][CIC_W] ? '1 : comb_q[c][CIC_W-1:0];
            wide  = XW'(clamp) << SHL;
            wide  = wide >> SHR;
            uval  = wide[WDTH-1:0];
            xval  = {~uval[WDTH-1], uval[WDTH-2:0]};
            yval  = xval - acc_q[c];

            u_d[c]   = u_q[c];
            s_d[c]   = s_q[c];
            acc_d[c] = acc_q[c];
            if (proc) begin
                u_d[c] = uval;
                s_d[c] = dc_en ? yval : xval;
                if (dc_en) begin
                    acc_d[c] = acc_q[c] + smp_t'($signed(yval) >>> DC_SHIFT);
                end
            end
            if (!en || !dc_en) begin
                acc_d[c] = '0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        ub_d     = ub_q;
        sb_d     = sb_q;
        ovr_set  = 1'b0;
        fire     = (state_q == S_SEND) && m_if.m_ready;
        at_last  = (chan_q == CHW'(NCH - 1));
        final_hs = fire && at_last;

        if (fire) begin
            if (at_last) begin
                state_d = S_IDLE;
                chan_d  = '0;
            end else begin
                chan_d = chan_q + CHW'(1);
            end
        end

        // A frame landing on the final handshake is taken; any other frame during SEND is lost.
        if (done_q) begin
            if ((state_q == S_IDLE) || final_hs) begin
                ub_d    = u_q;
                sb_d    = s_q;
                state_d = S_SEND;
                chan_d  = '0;
            end else begin
                ovr_set = 1'b1;
            end
        end

        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_in_q  <= '0;
            cnt_q     <= '0;
            tick_d1_q <= 1'b0;
            warm_q    <= '0;
            done_q    <= 1'b0;
            state_q   <= S_IDLE;
            chan_q    <= '0;
            ovr_q     <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                for (int s = 0; s < STGS; s++) begin
                    integ_q[c][s] <= '0;
                    cdly_q[c][s]  <= '0;
                end
                comb_q[c] <= '0;
                u_q[c]    <= '0;
                s_q[c]    <= '0;
                acc_q[c]  <= '0;
                ub_q[c]   <= '0;
                sb_q[c]   <= '0;
            end
        end else begin
            adc_in_q  <= adc_in_d;
            cnt_q     <= cnt_d;
            tick_d1_q <= tick_d1_d;
            warm_q    <= warm_d;
            done_q    <= done_d;
            state_q   <= state_d;
            chan_q    <= chan_d;
            ovr_q     <= ovr_d;
            for (int c = 0; c < NCH; c++) begin
                for (int s = 0; s < STGS; s++) begin
                    integ_q[c][s] <= integ_d[c][s];
                    cdly_q[c][s]  <= cdly_d[c][s];
                end
                comb_q[c] <= comb_d[c];
                u_q[c]    <= u_d[c];
                s_q[c]    <= s_d[c];
                acc_q[c]  <= acc_d[c];
                ub_q[c]   <= ub_d[c];
                sb_q[c]   <= sb_d[c];
            end
        end
    end

    assign adc_fb_pin    = adc_in_q;
    assign overrun       = ovr_q;
    assign dbg_seq_state = (state_q == S_SEND);

    assign m_if.m_valid = (state_q == S_SEND);
    assign m_if.m_chan  = chan_q;
    assign m_if.m_udata = ub_q[chan_q];
    assign m_if.m_sdata = sb_q[chan_q];
    assign m_if.m_last  = (state_q == S_SEND) && (chan_q == CHW'(NCH - 1));
endmodule
